xoodyak_cmd_sequencer: RTL and testbench
========================================

XOODYAK_CMD_SEQUENCER -- requirements
Module: xoodyak_cmd_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 352, meaning the core input_data width.
REQ-002 SHALL have parameter TEXT_W, default 192, meaning the core textout width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum cycles to wait for core_finished.
REQ-004 SHALL have port eph1, input, 1, the single clock; all flops rise on posedge eph1.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1, host command present.
REQ-007 SHALL have port cmd_ready, output, 1, sequencer accepts a command.
REQ-008 SHALL have port cmd_op, input, 3, opcode: 1 init, 2 nonce, 3 assoc, 4 crypt, 5 decrypt, 6 squeeze, 7 ratchet.
REQ-009 SHALL have port cmd_data, input, DATA_W, command payload.
REQ-010 SHALL have port core_opmode, output, 5: bit4 continue, bits2:0 op, bit3 always 0.
REQ-011 SHALL have port core_data, output, DATA_W, payload to core.
REQ-012 SHALL have port core_textout, input, TEXT_W, core result.
REQ-013 SHALL have port core_finished, input, 1, core completion pulse.
REQ-014 SHALL have port rsp_valid, output, 1, response present.
REQ-015 SHALL have port rsp_ready, input, 1, host accepts response.
REQ-016 SHALL have port rsp_data, output, TEXT_W, captured textout; zero for ops 1,2,3,7 and on error.
REQ-017 SHALL have port rsp_err, output, 1, response reports sequence or timeout error.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-019 SHALL assert cmd_ready only in IDLE; handshake is cmd_valid & cmd_ready, after which cmd_op and cmd_data are registered.
REQ-020 On handshake, cmd_op==0, or cmd_op!=1 with no open session, SHALL go to RESP with rsp_err=1 and no core opmode issued.
REQ-021 Otherwise SHALL go to ISSUE, driving core_opmode={cont,2'b00... op} and core_data from the registered command starting the next cycle.
REQ-022 cont SHALL be 1 iff the op equals the last successfully completed op and the session is open; init always has cont=0.
REQ-023 core_opmode and core_data SHALL hold stable through ISSUE and WAIT until core_finished is sampled high; ISSUE lasts exactly one cycle then WAIT.
REQ-024 core_finished sampled high in ISSUE or WAIT SHALL capture core_textout (masked to zero for ops 1,2,3,7), set rsp_err=0, move to RESP, and drive core_opmode=0 and core_data=0 from the next cycle.
REQ-025 core_finished in IDLE or RESP SHALL be ignored.
REQ-026 In RESP, rsp_valid=1 with rsp_data/rsp_err stable until rsp_ready; on handshake return to IDLE (cmd_ready=1 next cycle).
REQ-027 A successful init SHALL open the session; any error SHALL close it; last-completed-op SHALL be cleared when the session closes.
REQ-028 Minimum command-to-response latency SHALL be 2 cycles (handshake, ISSUE with finished, rsp_valid).

Reset
REQ-029 Reset SHALL asynchronously force IDLE, cmd_ready=1, core_opmode=0, core_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, session closed, timeout counter=0.
REQ-030 Reset mid-operation SHALL drop any in-flight command and pending response without a response being produced.

Configuration
REQ-031 Macro XOOD_TIMEOUT_EN, when defined, SHALL count cycles in ISSUE/WAIT; reaching TIMEOUT_CYCLES without core_finished SHALL drive core_opmode=0, go to RESP with rsp_err=1, rsp_data=0, and close the session.
REQ-032 Without XOOD_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL persist indefinitely until core_finished or reset.

Verification
REQ-033 After reset, cmd_op=4 -> rsp_err=1 after 1 cycle, core_opmode stays 0.
REQ-034 init with cmd_data=0x3839...3637 (key) followed by core_finished 6 cycles later -> core_opmode=0x01 held 6 cycles, rsp_valid with rsp_data=0, rsp_err=0.
REQ-035 Session open, assoc twice -> first core_opmode=0x03, second 0x13; crypt with core_textout=0x87a06d55... -> rsp_data=0x87a06d55....
REQ-036 rsp_ready held low 10 cycles -> rsp_valid, rsp_data stable, cmd_ready=0 throughout.
REQ-037 With XOOD_TIMEOUT_EN, TIMEOUT_CYCLES=64, no core_finished -> rsp_err=1 at cycle 64 of ISSUE/WAIT, next nonce returns rsp_err=1.
REQ-038 reset asserted in WAIT -> all outputs return to REQ-029 values immediately, no response emitted.

Source files
------------

// File: rtl/xoodyak_cmd_sequencer.sv
// Host-side command sequencer for a Xoodyak core: accepts one command at a time,
// drives the core opmode/payload, captures the result. Optional watchdog: XOOD_TIMEOUT_EN.
module xoodyak_cmd_sequencer #(
  parameter int DATA_W         = 352,
  parameter int TEXT_W         = 192,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              eph1,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [4:0]        core_opmode,
  output logic [DATA_W-1:0] core_data,
  input  logic [TEXT_W-1:0] core_textout,
  input  logic              core_finished,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TEXT_W-1:0] rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] OP_INIT = 3'd1;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [4:0]          core_opmode_q, core_opmode_d;
  logic [DATA_W-1:0]   core_data_q, core_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [TEXT_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [2:0]          op_q, op_d;
  logic                session_q, session_d;
  logic [2:0]          last_op_q, last_op_d;
`ifdef XOOD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic handshake, seq_err, cont, text_op;

  assign handshake = cmd_valid & cmd_ready_q;
  assign seq_err   = (cmd_op == 3'd0) || ((cmd_op != OP_INIT) && !session_q);
  // Init always starts a fresh absorb chain, so it never continues.
  assign cont      = session_q && (cmd_op == last_op_q) && (cmd_op != OP_INIT);
  // Only crypt, decrypt and squeeze return core text to the host.
  assign text_op   = (op_q == 3'd4) || (op_q == 3'd5) || (op_q == 3'd6);

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case leaves a latch.
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    core_opmode_d = core_opmode_q;
    core_data_d   = core_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    op_d          = op_q;
    session_d     = session_q;
    last_op_d     = last_op_q;
`ifdef XOOD_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (handshake) begin
        op_d        = cmd_op;
        cmd_ready_d = 1'b0;
        if (seq_err) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          session_d   = 1'b0;
          last_op_d   = '0;
        end else begin
          state_d       = S_ISSUE;
          core_opmode_d = {cont, 1'b0, cmd_op};
          core_data_d   = cmd_data;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (core_finished) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b0;
          rsp_data_d    = text_op ? core_textout : '0;
          core_opmode_d = '0;
          core_data_d   = '0;
          last_op_d     = op_q;
          if (op_q == OP_INIT) session_d = 1'b1;
`ifdef XOOD_TIMEOUT_EN
          cnt_d         = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_data_d    = '0;
          core_opmode_d = '0;
          core_data_d   = '0;
          session_d     = 1'b0;
          last_op_d     = '0;
          cnt_d         = '0;
        end else begin
          cnt_d         = cnt_q + 1'b1;
          state_d       = S_WAIT;
`else
        end else begin
          state_d       = S_WAIT;
`endif
        end
      end
      S_RESP: if (rsp_ready) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together.
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      core_opmode_q <= '0;
      core_data_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      op_q          <= '0;
      session_q     <= 1'b0;
      last_op_q     <= '0;
`ifdef XOOD_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      core_opmode_q <= core_opmode_d;
      core_data_q   <= core_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      op_q          <= op_d;
      session_q     <= session_d;
      last_op_q     <= last_op_d;
`ifdef XOOD_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign core_opmode = core_opmode_q;
  assign core_data   = core_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_xoodyak_cmd_sequencer.sv
// Self-checking bench for xoodyak_cmd_sequencer: directed steps plus random commands
// scored against a session/last-op reference model.
module tb_xoodyak_cmd_sequencer;

  localparam int DW = 352;
  localparam int TW = 192;
  localparam int TO = 64;

  logic          eph1 = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [4:0]    core_opmode;
  logic [DW-1:0] core_data;
  logic [TW-1:0] core_textout;
  logic          core_finished;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [TW-1:0] rsp_data;
  logic          rsp_err;

  xoodyak_cmd_sequencer #(.DATA_W(DW), .TEXT_W(TW), .TIMEOUT_CYCLES(TO)) dut (
    .eph1(eph1), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .core_opmode(core_opmode), .core_data(core_data),
    .core_textout(core_textout), .core_finished(core_finished),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 eph1 = ~eph1;

  int total  = 0;
  int passed = 0;

  // Reference model state: is a session open, and which op last completed.
  bit       session;
  logic [2:0] last_op;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [TW-1:0] rnd_text();
    logic [TW-1:0] r;
    for (int i = 0; i < TW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"},   cmd_ready,   1'b1);
    check({tag, "_core_opmode"}, core_opmode, 5'd0);
    check({tag, "_core_data"},   core_data,   '0);
    check({tag, "_rsp_valid"},   rsp_valid,   1'b0);
    check({tag, "_rsp_data"},    rsp_data,    '0);
    check({tag, "_rsp_err"},     rsp_err,     1'b0);
  endtask

  // One complete command: handshake, core activity, response, host accept.
  task automatic do_cmd(input logic [2:0] op, input logic [DW-1:0] data, input int fin_delay,
                        input logic [TW-1:0] text, input int rsp_wait);
    logic          exp_err;
    logic [4:0]    exp_mode;
    logic [TW-1:0] exp_rsp;
    exp_err  = (op == 3'd0) || (op != 3'd1 && !session);
    exp_mode = {(session && op == last_op && op != 3'd1), 1'b0, op};
    exp_rsp  = (!exp_err && (op == 3'd4 || op == 3'd5 || op == 3'd6)) ? text : '0;

    @(negedge eph1);
    check("idle_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(negedge eph1);
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = rnd_data();

    if (exp_err) begin
      session = 1'b0;
      last_op = 3'd0;
    end else begin
      for (int k = 0; k <= fin_delay; k++) begin
        check("opmode_held", core_opmode, exp_mode);
        check("data_held",   core_data,   data);
        check("no_rsp_yet",  rsp_valid,   1'b0);
        if (k == fin_delay) begin
          core_finished = 1'b1;
          core_textout  = text;
        end
        @(negedge eph1);
      end
      core_finished = 1'b0;
      core_textout  = rnd_text();
      if (op == 3'd1) session = 1'b1;
      last_op = op;
    end

    check("rsp_valid",      rsp_valid,   1'b1);
    check("rsp_err",        rsp_err,     exp_err);
    check("rsp_data",       rsp_data,    exp_rsp);
    check("opmode_cleared", core_opmode, 5'd0);
    check("data_cleared",   core_data,   '0);
    check("busy_not_ready", cmd_ready,   1'b0);

    // Stray core_finished pulses while a response is pending must be ignored.
    for (int k = 0; k < rsp_wait; k++) begin
      core_finished = 1'($urandom_range(0, 1));
      @(negedge eph1);
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rsp_data",  rsp_data,  exp_rsp);
      check("hold_rsp_err",   rsp_err,   exp_err);
      check("hold_not_ready", cmd_ready, 1'b0);
      check("hold_opmode",    core_opmode, 5'd0);
    end
    core_finished = 1'b0;
    rsp_ready = 1'b1;
    @(negedge eph1);
    rsp_ready = 1'b0;
    check("rsp_dropped",  rsp_valid, 1'b0);
    check("ready_return", cmd_ready, 1'b1);
  endtask

  initial begin
    logic [2:0] op;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0;
    core_textout = '0; core_finished = 1'b0; rsp_ready = 1'b0;
    session = 1'b0; last_op = 3'd0;
    #12;
    check_reset_values("reset");
    @(negedge eph1);
    reset = 1'b0;

    // Crypt with no session is a sequence error.
    do_cmd(3'd4, rnd_data(), 0, rnd_text(), 0);
    // Init with a key, finished after six cycles of issue/wait.
    do_cmd(3'd1, DW'(128'h38393a3b3c3d3e3f3031323334353637), 5, rnd_text(), 0);
    // Assoc twice: second one continues; crypt returns text.
    do_cmd(3'd3, rnd_data(), 1, rnd_text(), 0);
    do_cmd(3'd3, rnd_data(), 0, rnd_text(), 0);
    do_cmd(3'd4, rnd_data(), 2,
           192'h87a06d55_1f2e3d4c_5b6a7988_99aabbcc_ddeeff00_11223344, 10);
    // Opcode 0 closes the session; nonce afterwards also errors.
    do_cmd(3'd0, rnd_data(), 0, rnd_text(), 1);
    do_cmd(3'd2, rnd_data(), 0, rnd_text(), 0);

    // Reset while the core is busy drops the command silently.
    do_cmd(3'd1, rnd_data(), 0, rnd_text(), 0);
    @(negedge eph1);
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_data = rnd_data();
    @(negedge eph1);
    cmd_valid = 1'b0;
    @(negedge eph1);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    @(negedge eph1);
    reset = 1'b0;
    session = 1'b0; last_op = 3'd0;
    repeat (2) begin
      @(negedge eph1);
      check("post_reset_no_rsp", rsp_valid, 1'b0);
      check("post_reset_ready",  cmd_ready, 1'b1);
    end
    do_cmd(3'd5, rnd_data(), 0, rnd_text(), 0);

`ifdef XOOD_TIMEOUT_EN
    do_cmd(3'd1, rnd_data(), 0, rnd_text(), 0);
    @(negedge eph1);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = rnd_data();
    @(negedge eph1);
    cmd_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      check("to_waiting", rsp_valid, 1'b0);
      @(negedge eph1);
    end
    check("to_rsp_valid", rsp_valid,   1'b1);
    check("to_rsp_err",   rsp_err,     1'b1);
    check("to_rsp_data",  rsp_data,    '0);
    check("to_opmode",    core_opmode, 5'd0);
    rsp_ready = 1'b1;
    @(negedge eph1);
    rsp_ready = 1'b0;
    session = 1'b0; last_op = 3'd0;
    do_cmd(3'd2, rnd_data(), 0, rnd_text(), 0);
`endif

    // Random command stream, biased toward init and repeated ops.
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      if (!session && $urandom_range(0, 1) == 1) op = 3'd1;
      else if (last_op != 3'd0 && $urandom_range(0, 2) == 0) op = last_op;
      do_cmd(op, rnd_data(), int'($urandom_range(0, 5)), rnd_text(), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
